// File: rtl/nn_neuron_mac.sv
// Single-neuron MAC: latches N signed operand pairs plus a bias, then accumulates one product per cycle.
// Produces a saturated 16-bit result. Define NN_MAC_RELU_EN to zero negative results after clamping.
//
// state  | meaning
// S_IDLE | waiting for start_i; latches operands and preloads acc with the bias
// S_MAC  | one product per cycle into acc, idx walks 0..N_INPUTS-1
// S_OUT  | clamp (and optional ReLU), publish result, pulse done
module nn_neuron_mac #(
  parameter int N_INPUTS = 4,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         start_i,
  input  logic [N_INPUTS*DATA_W-1:0]   inputs_i,
  input  logic [N_INPUTS*DATA_W-1:0]   weights_i,
  input  logic [15:0]                  bias_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [15:0]                  result_o,
  output logic                         sat_o
);

  localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [DATA_W-1:0]   in_q [N_INPUTS];
  logic signed [DATA_W-1:0]   in_d [N_INPUTS];
  logic signed [DATA_W-1:0]   w_q  [N_INPUTS];
  logic signed [DATA_W-1:0]   w_d  [N_INPUTS];
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [15:0]                result_q, result_d;
  logic                       sat_q, sat_d;

  logic signed [2*DATA_W-1:0] op_a, op_b, prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic [15:0]                clamp_val;
  logic                       clamp_hit;
  logic [15:0]                final_val;

  always_comb begin
    op_a     = {{DATA_W{in_q[idx_q][DATA_W-1]}}, in_q[idx_q]};
    op_b     = {{DATA_W{w_q[idx_q][DATA_W-1]}}, w_q[idx_q]};
    prod     = op_a * op_b;
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  end

  always_comb begin
    clamp_val = acc_q[15:0];
    clamp_hit = 1'b0;
    if (acc_q > ACC_MAX) begin
      clamp_val = 16'h7FFF;
      clamp_hit = 1'b1;
    end else if (acc_q < ACC_MIN) begin
      clamp_val = 16'h8000;
      clamp_hit = 1'b1;
    end
`ifdef NN_MAC_RELU_EN
    // ReLU is applied after the clamp; it never contributes to sat_o
    final_val = clamp_val[15] ? 16'h0000 : clamp_val;
`else
    final_val = clamp_val;
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    in_d     = in_q;
    w_d      = w_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    sat_d    = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          for (int k = 0; k < N_INPUTS; k++) begin
            in_d[k] = inputs_i[k*DATA_W +: DATA_W];
            w_d[k]  = weights_i[k*DATA_W +: DATA_W];
          end
          acc_d   = {{(ACC_W-16){bias_i[15]}}, bias_i};
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = S_OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_OUT: begin
        result_d = final_val;
        sat_d    = clamp_hit;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      sat_q    <= 1'b0;
      for (int k = 0; k < N_INPUTS; k++) begin
        in_q[k] <= '0;
        w_q[k]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      in_q     <= in_d;
      w_q      <= w_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign sat_o    = sat_q;

endmodule

// File: tb/tb_nn_neuron_mac.sv
// Directed bench for nn_neuron_mac with a result scoreboard; follows NN_MAC_RELU_EN if defined.
module tb_nn_neuron_mac;

  logic        ACLK;
  logic        ARESET;
  logic        start_i;
  logic [31:0] inputs_i;
  logic [31:0] weights_i;
  logic [15:0] bias_i;
  logic        busy_o;
  logic        done_o;
  logic [15:0] result_o;
  logic        sat_o;

  nn_neuron_mac #(.N_INPUTS(4), .DATA_W(8), .ACC_W(24)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start_i(start_i),
    .inputs_i(inputs_i), .weights_i(weights_i), .bias_i(bias_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .sat_o(sat_o)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int compared = 0;
  int mism     = 0;
  int cur_in [4];
  int cur_w  [4];
  int cur_b;
  int res_q [$];
  int sat_q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i0, input int i1, input int i2, input int i3,
                         input int w0, input int w1, input int w2, input int w3,
                         input int b);
    cur_in[0] = i0; cur_in[1] = i1; cur_in[2] = i2; cur_in[3] = i3;
    cur_w[0]  = w0; cur_w[1]  = w1; cur_w[2]  = w2; cur_w[3]  = w3;
    cur_b = b;
    for (int k = 0; k < 4; k++) begin
      inputs_i[k*8 +: 8]  = 8'(cur_in[k]);
      weights_i[k*8 +: 8] = 8'(cur_w[k]);
    end
    bias_i = 16'(b);
  endtask

  task automatic push_expected();
    int acc;
    int res;
    int sat;
    acc = cur_b;
    for (int k = 0; k < 4; k++) acc += cur_in[k] * cur_w[k];
    sat = 0;
    res = acc;
    if (acc > 32767) begin res = 32767; sat = 1; end
    else if (acc < -32768) begin res = -32768; sat = 1; end
`ifdef NN_MAC_RELU_EN
    if (res < 0) res = 0;
`endif
    res_q.push_back(res);
    sat_q.push_back(sat);
  endtask

  task automatic check_done(input string tag);
    if (res_q.size() == 0) begin
      chk({tag, "_unexpected_done"}, 1, 0);
    end else begin
      chk({tag, "_result"}, int'($signed(result_o)), res_q.pop_front());
      chk({tag, "_sat"}, int'(sat_o), sat_q.pop_front());
    end
  endtask

  // Start is sampled at the edge after this negedge; done expected 5 edges later.
  task automatic run_op(input string tag);
    int cyc;
    int busy_cnt;
    start_i = 1'b1;
    push_expected();
    @(negedge ACLK);
    start_i  = 1'b0;
    cyc      = 0;
    busy_cnt = int'(busy_o);
    while (!done_o && cyc < 50) begin
      @(negedge ACLK);
      cyc++;
      if (busy_o) busy_cnt++;
    end
    chk({tag, "_done_seen"}, int'(done_o), 1);
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_busy_cycles"}, busy_cnt, 5);
    if (done_o) check_done(tag);
    @(negedge ACLK);
    chk({tag, "_done_pulse_width"}, int'(done_o), 0);
  endtask

  initial begin
    int dones;
    int last;
    ARESET  = 1'b1;
    start_i = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge ACLK);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_sat", int'(sat_o), 0);
    ARESET = 1'b0;
    @(negedge ACLK);

    set_ops(1, 2, 3, 4, 1, 1, 1, 1, 10);
    run_op("basic");
    set_ops(127, 127, 127, 127, 127, 127, 127, 127, 32767);
    run_op("pos_sat");
    set_ops(-128, -128, -128, -128, 127, 127, 127, 127, -32768);
    run_op("neg_sat");
    set_ops(-5, 0, 0, 0, 3, 0, 0, 0, 0);
    run_op("neg15");
    set_ops(-7, 9, 100, -3, 11, -2, 5, 40, -200);
    run_op("mixed");

    // Second start and operand change mid-run must not disturb the first result
    set_ops(2, 3, 4, 5, 6, 7, 8, 9, 1);
    start_i = 1'b1;
    push_expected();
    @(negedge ACLK);
    start_i = 1'b0;
    @(negedge ACLK);
    start_i = 1'b1;
    set_ops(50, 50, 50, 50, -50, -50, -50, -50, 0);
    @(negedge ACLK);
    start_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      if (done_o) begin
        dones++;
        check_done("midrun");
      end
    end
    chk("midrun_done_count", dones, 1);

    // Reset sampled at the third edge of a run aborts it
    set_ops(10, 10, 10, 10, 10, 10, 10, 10, 5);
    start_i = 1'b1;
    @(negedge ACLK);
    start_i = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_done", int'(done_o), 0);
    chk("abort_result", int'(result_o), 0);
    chk("abort_sat", int'(sat_o), 0);
    ARESET = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      if (done_o) dones++;
    end
    chk("abort_no_done", dones, 0);
    set_ops(-1, 2, -3, 4, 5, -6, 7, -8, 100);
    run_op("after_abort");

    // Held start: accepted at edges 0,6,12,18 -> four dones six cycles apart
    set_ops(3, -4, 5, -6, 7, 8, -9, 10, -33);
    start_i = 1'b1;
    repeat (4) push_expected();
    dones = 0;
    last  = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge ACLK);
      if (i == 19) start_i = 1'b0;
      if (done_o) begin
        if (last >= 0) chk("held_interval", i - last, 6);
        else chk("held_first_done", i, 5);
        last = i;
        dones++;
        check_done("held");
      end
    end
    chk("held_done_count", dones, 4);
    chk("scoreboard_empty", res_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
